// File: rtl/buffer_aa_writer_pkg.sv
// Shared encodings and defaults for buffer_AA, its writer front end and the qa wrappers.
package buffer_aa_writer_pkg;

  typedef enum logic [0:0] {
    RUN = 1'b0,
    ERR = 1'b1
  } state_t;

  localparam int BUFFER_LENGTH     = 8;
  localparam int LOG_BUFFER_LENGTH = 3;

  localparam logic [1:0] WRITEERRORCODE = 2'b01;
  localparam logic [1:0] READERRORCODE  = 2'b10;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/skid_buffer_2.sv
// Two-entry valid/ready register slice with registered ready. When empty, an incoming word
// bypasses straight to the output so the consumer can take it in the same cycle it is accepted.
module skid_buffer_2 #(
  parameter int WDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [WDTH-1:0] i_data,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_block,
  output logic [WDTH-1:0] o_data,
  output logic            o_valid,
  input  logic            i_ready
);

  logic [1:0]      r_count;
  logic [WDTH-1:0] r_head;
  logic [WDTH-1:0] r_spare;
  logic            r_ready;
  logic            w_push;
  logic            w_pop;
  logic [1:0]      w_count_next;

  assign w_push  = i_valid && r_ready;
  assign o_valid = (r_count != 2'd0) || w_push;
  assign o_data  = (r_count != 2'd0) ? r_head : i_data;
  assign w_pop   = o_valid && i_ready;
  assign o_ready = r_ready;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_spare <= '0;
      r_ready <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_ready <= (w_count_next < 2'd2) && !i_block;
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_data;
          else                 r_spare <= i_data;
        end
        2'b01: r_head <= r_spare;
        2'b11: begin
          // Empty skid with push+pop is a pure bypass; nothing is stored.
          if (r_count == 2'd2) begin
            r_head  <= r_spare;
            r_spare <= i_data;
          end else if (r_count == 2'd1) begin
            r_head <= i_data;
          end else begin
            r_head <= r_head;
          end
        end
        default: r_head <= r_head;
      endcase
    end
  end

endmodule

// File: rtl/buffer_aa_writer.sv
// Producer front end for buffer_AA: strobes a word only into a slot reported empty, mirrors the write pointer.
// Optional BUFFER_AA_WRITER_STATS_EN adds saturating stall/word counters.
module buffer_aa_writer
  import buffer_aa_writer_pkg::*;
#(
  parameter int WDTH        = 32,
  parameter int BUF_LEN     = BUFFER_LENGTH,
  parameter int LOG_BUF_LEN = LOG_BUFFER_LENGTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WDTH-1:0]        i_in_data,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  output logic                   o_write_strobe,
  output logic [WDTH-1:0]        o_write_data,
  input  logic [BUF_LEN-1:0]     i_full,
  input  logic                   i_write_error,
  output logic                   o_error,
`ifdef BUFFER_AA_WRITER_STATS_EN
  output logic [LOG_BUF_LEN-1:0] o_waddr,
  output logic [15:0]            o_stall_count,
  output logic [15:0]            o_word_count
`else
  output logic [LOG_BUF_LEN-1:0] o_waddr
`endif
);

  state_t                 r_state;
  logic [LOG_BUF_LEN-1:0] r_waddr;
  logic                   r_strobe;
  logic [WDTH-1:0]        r_wdata;
  logic                   r_error;
  logic                   w_head_valid;
  logic [WDTH-1:0]        w_head_data;
  logic                   w_slot_full;
  logic                   w_can_issue;
  logic                   w_issue;
  logic                   w_err_next;
  logic [LOG_BUF_LEN-1:0] w_waddr_inc;

  assign w_slot_full = i_full[r_waddr];
  // write_error beats a same-cycle issue, so it gates the pop as well as the strobe.
  assign w_can_issue = (r_state == RUN) && !i_write_error && !w_slot_full;
  assign w_issue     = w_can_issue && w_head_valid;
  assign w_err_next  = (r_state == ERR) || i_write_error;
  assign w_waddr_inc = (r_waddr == LOG_BUF_LEN'(BUF_LEN - 1)) ? '0 : r_waddr + LOG_BUF_LEN'(1);

  skid_buffer_2 #(.WDTH(WDTH)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  (i_in_data),
    .i_valid (i_in_valid),
    .o_ready (o_in_ready),
    .i_block (w_err_next),
    .o_data  (w_head_data),
    .o_valid (w_head_valid),
    .i_ready (w_can_issue)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_strobe <= 1'b0;
      r_wdata  <= '0;
      r_error  <= 1'b0;
      r_waddr  <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (i_write_error) begin
            r_state  <= ERR;
            r_error  <= 1'b1;
            r_strobe <= 1'b0;
          end else begin
            r_strobe <= w_issue;
            if (w_issue) begin
              r_wdata <= w_head_data;
              r_waddr <= w_waddr_inc;
            end
          end
        end
        ERR: begin
          r_strobe <= 1'b0;
          r_error  <= 1'b1;
        end
        default: begin
          r_state  <= ERR;
          r_strobe <= 1'b0;
          r_error  <= 1'b1;
        end
      endcase
    end
  end

  assign o_write_strobe = r_strobe;
  assign o_write_data   = r_wdata;
  assign o_error        = r_error;
  assign o_waddr        = r_waddr;

`ifdef BUFFER_AA_WRITER_STATS_EN
  logic [15:0] r_stall_count;
  logic [15:0] r_word_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_count <= 16'd0;
      r_word_count  <= 16'd0;
    end else begin
      if (w_head_valid && w_slot_full) r_stall_count <= sat_inc16(r_stall_count);
      if (w_issue)                     r_word_count  <= sat_inc16(r_word_count);
    end
  end

  assign o_stall_count = r_stall_count;
  assign o_word_count  = r_word_count;
`endif

endmodule

// File: tb/tb_buffer_aa_writer.sv
// Bench for buffer_aa_writer (BUF_LEN=4): directed vector table, spec scenarios against an emulated
// buffer_AA, then randomized traffic checked against a queue-based reference model.
module tb_buffer_aa_writer;

  localparam int W   = 32;
  localparam int BL  = 4;
  localparam int LBL = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  i_in_data;
  logic          i_in_valid;
  logic          o_in_ready;
  logic          o_write_strobe;
  logic [W-1:0]  o_write_data;
  logic [BL-1:0] i_full;
  logic          i_write_error;
  logic          o_error;
  logic [LBL-1:0] o_waddr;
`ifdef BUFFER_AA_WRITER_STATS_EN
  logic [15:0]   o_stall_count;
  logic [15:0]   o_word_count;
`endif

  buffer_aa_writer #(.WDTH(W), .BUF_LEN(BL), .LOG_BUF_LEN(LBL)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_in_data      (i_in_data),
    .i_in_valid     (i_in_valid),
    .o_in_ready     (o_in_ready),
    .o_write_strobe (o_write_strobe),
    .o_write_data   (o_write_data),
    .i_full         (i_full),
    .i_write_error  (i_write_error),
    .o_error        (o_error),
`ifdef BUFFER_AA_WRITER_STATS_EN
    .o_stall_count  (o_stall_count),
    .o_word_count   (o_word_count),
`endif
    .o_waddr        (o_waddr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending words in order, mirrored pointer, error flag.
  logic [31:0] q[$];
  logic        m_ready = 1'b0, m_strobe = 1'b0, m_err = 1'b0;
  logic [31:0] m_data = 32'd0;
  int          m_waddr = 0, m_stall = 0, m_words = 0;

  // Emulated buffer_AA with an in-order reader.
  logic [BL-1:0] occ = '0;
  logic [31:0]   mem[BL];
  int            rptr = 0, env_slot = 0, strobe_seen = 0;
  logic          drain = 1'b1, force_en = 1'b0;
  logic [BL-1:0] force_val = '0;
  logic [31:0]   out_q[$];

  typedef struct {
    logic        rn;
    logic        v;
    logic [31:0] d;
    logic [3:0]  full;
    logic        we;
    logic        e_rdy;
    logic        e_stb;
    logic [31:0] e_data;
    logic [1:0]  e_waddr;
    logic        e_err;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic we, input logic rn);
    logic        pw;
    int          ps;
    logic [31:0] pd;
    pw = m_strobe;
    ps = env_slot;
    pd = m_data;
    i_in_valid    = v;
    i_in_data     = d;
    i_write_error = we;
    rst_n         = rn;
    i_full        = force_en ? force_val : occ;
    if (!rn) begin
      q.delete();
      m_ready = 1'b0; m_strobe = 1'b0; m_err = 1'b0; m_data = 32'd0;
      m_waddr = 0; m_stall = 0; m_words = 0; env_slot = 0;
    end else begin
      if (v && m_ready) q.push_back(d);
      if (q.size() > 0 && i_full[m_waddr] && m_stall < 65535) m_stall++;
      m_strobe = !m_err && !we && q.size() > 0 && !i_full[m_waddr];
      if (m_strobe) begin
        m_data   = q.pop_front();
        env_slot = m_waddr;
        m_waddr  = (m_waddr + 1) % BL;
        if (m_words < 65535) m_words++;
      end
      if (we) m_err = 1'b1;
      m_ready = (q.size() < 2) && !m_err;
    end
    @(posedge clk);
    if (!rn) begin
      occ  = '0;
      rptr = 0;
    end else begin
      if (drain && occ[rptr]) begin
        out_q.push_back(mem[rptr]);
        occ[rptr] = 1'b0;
        rptr = (rptr + 1) % BL;
      end
      if (pw) begin
        occ[ps] = 1'b1;
        mem[ps] = pd;
      end
    end
    #1;
    if (o_write_strobe === 1'b1) strobe_seen++;
    check("in_ready", o_in_ready, m_ready);
    check("write_strobe", o_write_strobe, m_strobe);
    if (m_strobe || !rn) check("write_data", o_write_data, m_data);
    check("error", o_error, m_err);
    check("waddr", o_waddr, m_waddr);
`ifdef BUFFER_AA_WRITER_STATS_EN
    check("stall_count", o_stall_count, m_stall);
    check("word_count", o_word_count, m_words);
`endif
  endtask

  task automatic do_reset();
    step(1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    out_q.delete();
    strobe_seen = 0;
  endtask

  initial begin
    int idx, acc, n;
    logic a, v;
    rst_n = 1'b0; i_in_valid = 1'b0; i_in_data = '0; i_full = '0; i_write_error = 1'b0;

    //            rn    v     d      full    we    rdy   stb   data   wa    err
    tbl[0]  = '{1'b0, 1'b0, 32'h0,  4'h0, 1'b0, 1'b0, 1'b0, 32'h0,  2'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,  4'h0, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 32'hA1, 4'h0, 1'b0, 1'b1, 1'b1, 32'hA1, 2'd1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 32'hA2, 4'h0, 1'b0, 1'b1, 1'b1, 32'hA2, 2'd2, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 32'hA3, 4'h4, 1'b0, 1'b1, 1'b0, 32'h0,  2'd2, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 32'hA4, 4'h4, 1'b0, 1'b0, 1'b0, 32'h0,  2'd2, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 32'hA5, 4'h4, 1'b0, 1'b0, 1'b0, 32'h0,  2'd2, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,  4'h0, 1'b0, 1'b1, 1'b1, 32'hA3, 2'd3, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,  4'h0, 1'b0, 1'b1, 1'b1, 32'hA4, 2'd0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,  4'h0, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 32'hA6, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0,  2'd0, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 32'hA7, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0,  2'd0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 32'h0,  4'h0, 1'b0, 1'b0, 1'b0, 32'h0,  2'd0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 32'h0,  4'h0, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      rst_n = tbl[i].rn; i_in_valid = tbl[i].v; i_in_data = tbl[i].d;
      i_full = tbl[i].full; i_write_error = tbl[i].we;
      @(posedge clk);
      #1;
      check("tbl_in_ready", o_in_ready, tbl[i].e_rdy);
      check("tbl_strobe", o_write_strobe, tbl[i].e_stb);
      if (tbl[i].e_stb || !tbl[i].rn) check("tbl_data", o_write_data, tbl[i].e_data);
      check("tbl_waddr", o_waddr, tbl[i].e_waddr);
      check("tbl_error", o_error, tbl[i].e_err);
    end

    // Stream 0x1..0x10 with an always-draining reader.
    do_reset();
    idx = 1;
    for (int c = 0; c < 200 && idx <= 16; c++) begin
      a = m_ready;
      step(1'b1, idx, 1'b0, 1'b1);
      if (a) idx++;
    end
    for (int c = 0; c < 20; c++) step(1'b0, 32'd0, 1'b0, 1'b1);
    check("t1_count", out_q.size(), 16);
    for (int i = 0; i < out_q.size(); i++) check("t1_order", out_q[i], i + 1);
    check("t1_waddr", o_waddr, 0);
    check("t1_error", o_error, 0);

    // Stalled reader: six words in, four strobes, two held in the skid.
    do_reset();
    drain = 1'b0;
    acc = 0;
    for (int c = 0; c < 40 && acc < 6; c++) begin
      a = m_ready;
      step(1'b1, 32'h20 + acc, 1'b0, 1'b1);
      if (a) acc++;
    end
    for (int c = 0; c < 5; c++) step(1'b0, 32'd0, 1'b0, 1'b1);
    check("t2_strobes", strobe_seen, 4);
    check("t2_ready_low", o_in_ready, 0);
    drain = 1'b1;
    for (int c = 0; c < 30; c++) step(1'b0, 32'd0, 1'b0, 1'b1);
    check("t2_count", out_q.size(), 6);
    for (int i = 0; i < out_q.size(); i++) check("t2_order", out_q[i], 32'h20 + i);

    // full[waddr] held for five cycles with a head word.
    do_reset();
    force_en = 1'b1; force_val = 4'b0001;
    step(1'b1, 32'hAB, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) step(1'b0, 32'd0, 1'b0, 1'b1);
    check("t3_held", strobe_seen, 0);
    force_val = 4'b0000;
    step(1'b0, 32'd0, 1'b0, 1'b1);
    check("t3_released", strobe_seen, 1);
    check("t3_data", o_write_data, 32'hAB);
`ifdef BUFFER_AA_WRITER_STATS_EN
    check("t3_stall_count", o_stall_count, 5);
`endif
    force_en = 1'b0;

    // write_error mid-stream is sticky until reset.
    do_reset();
    for (int c = 0; c < 10; c++) step(1'b1, 32'h40 + c, (c == 3), 1'b1);
    check("t4_error", o_error, 1);
    check("t4_ready", o_in_ready, 0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    check("t4_error_cleared", o_error, 0);
    check("t4_waddr", o_waddr, 0);

    // Reset with two words held discards them.
    do_reset();
    drain = 1'b0; force_en = 1'b1; force_val = 4'hF;
    for (int c = 0; c < 3; c++) step(1'b1, 32'h60 + c, 1'b0, 1'b1);
    check("t5_skid_full", o_in_ready, 0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    force_en = 1'b0; drain = 1'b1; strobe_seen = 0;
    step(1'b0, 32'd0, 1'b0, 1'b1);
    check("t5_ready", o_in_ready, 1);
    for (int c = 0; c < 5; c++) step(1'b0, 32'd0, 1'b0, 1'b1);
    check("t5_no_strobe", strobe_seen, 0);

    // Alternating valid: one strobe per accepted word, pointer wraps.
    do_reset();
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      v = (c % 2 == 0);
      if (v && m_ready) acc++;
      step(v, $urandom, 1'b0, 1'b1);
    end
    for (int c = 0; c < 10; c++) step(1'b0, 32'd0, 1'b0, 1'b1);
    check("t6_strobes", strobe_seen, acc);
    check("t6_waddr", o_waddr, acc % BL);

    // Randomized traffic against the reference model.
    do_reset();
    n = 0;
    for (int c = 0; c < 600; c++) begin
      drain = ($urandom_range(0, 9) < 7);
      if (m_err && $urandom_range(0, 7) == 0)
        step(1'b0, 32'd0, 1'b0, 1'b0);
      else if ($urandom_range(0, 199) == 0)
        step(1'b0, 32'd0, 1'b0, 1'b0);
      else
        step($urandom_range(0, 3) != 0, $urandom, ($urandom_range(0, 149) == 0), 1'b1);
      n++;
    end
    check("rand_cycles", n, 600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
